// File: rtl/tile_thread_dispatcher_pkg.sv
// Shared types for the tile thread dispatcher: dispatch mode and control states.
package tile_thread_dispatcher_pkg;

    typedef enum logic {
        INTERLEAVED = 1'b0,
        DYNAMIC     = 1'b1
    } dispatch_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } disp_state_e;

endpackage

// File: rtl/tile_thread_dispatcher_free_lane_compactor.sv
// Prefix count over free lanes: each lane's pixel offset among the free lanes
// below it, plus the total number of free lanes.
module free_lane_compactor #(
    parameter  int NUM_CORES = 4,
    localparam int OFF_W     = $clog2(NUM_CORES + 1)
) (
    input  logic [NUM_CORES-1:0]            free,
    output logic [NUM_CORES-1:0][OFF_W-1:0] offset,
    output logic [OFF_W-1:0]                total
);

    always_comb begin
        logic [OFF_W-1:0] acc;
        acc    = '0;
        offset = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            offset[i] = acc;
            acc       = acc + OFF_W'(free[i]);
        end
        total = acc;
    end

endmodule

// File: rtl/tile_thread_dispatcher.sv
// Walks a TILE_W x TILE_H pixel tile row-major and issues one thread coordinate
// per ray-core lane per cycle, honouring per-core FIFO-full backpressure.
module tile_thread_dispatcher
    import tile_thread_dispatcher_pkg::*;
#(
    parameter  int NUM_CORES = 4,
    parameter  int TILE_W    = 16,
    parameter  int TILE_H    = 16,
    parameter  int COORD_W   = 12,
    localparam int CNT_W     = $clog2(TILE_W * TILE_H + 1)
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              strobe,
    input  logic                              abort,
    input  logic                              mode,
    input  logic [COORD_W-1:0]                x0,
    input  logic [COORD_W-1:0]                y0,
    input  logic [NUM_CORES-1:0]              core_full,
    output logic [NUM_CORES-1:0]              thread_valid,
    output logic [NUM_CORES-1:0][COORD_W-1:0] thread_x,
    output logic [NUM_CORES-1:0][COORD_W-1:0] thread_y,
    output logic                              busy,
    output logic                              done,
    output logic [CNT_W-1:0]                  issued_count
);

    localparam int TOTAL = TILE_W * TILE_H;
    localparam int OFF_W = $clog2(NUM_CORES + 1);
    localparam int PX_W  = $clog2(2 * TILE_W);
    localparam int PY_W  = $clog2(TILE_H + 1);

    if (TILE_W % NUM_CORES != 0) begin : g_bad_cfg
        $error("tile_thread_dispatcher: TILE_W must be a multiple of NUM_CORES");
    end

    disp_state_e                       state, state_nxt;
    dispatch_mode_e                    mode_q;
    logic [COORD_W-1:0]                x0_q, y0_q;
    logic [PX_W-1:0]                   px, px_sum, px_nxt;
    logic [PY_W-1:0]                   py, py_nxt;
    logic [CNT_W-1:0]                  remaining;
    logic [NUM_CORES-1:0]              free, lane_go;
    logic [NUM_CORES-1:0][OFF_W-1:0]   dyn_off, lane_off;
    logic [OFF_W-1:0]                  dyn_total, n_issue;
    logic [NUM_CORES-1:0][COORD_W-1:0] lane_x, lane_y;

    assign free      = ~core_full;
    assign remaining = CNT_W'(TOTAL) - issued_count;

    free_lane_compactor #(.NUM_CORES(NUM_CORES)) u_compactor (
        .free   (free),
        .offset (dyn_off),
        .total  (dyn_total)
    );

    // Interleaved mode is all-or-nothing; dynamic mode packs free lanes and is
    // clipped to the pixels left in the tile.
    always_comb begin
        lane_go = '0;
        n_issue = '0;
        for (int i = 0; i < NUM_CORES; i++) lane_off[i] = OFF_W'(i);
        if (state == ST_RUN && !abort && remaining != '0) begin
            if (mode_q == INTERLEAVED) begin
                if (&free) begin
                    lane_go = '1;
                    n_issue = OFF_W'(NUM_CORES);
                end
            end else begin
                lane_off = dyn_off;
                for (int i = 0; i < NUM_CORES; i++)
                    lane_go[i] = free[i] && (CNT_W'(dyn_off[i]) < remaining);
                n_issue = (CNT_W'(dyn_total) <= remaining) ? dyn_total : OFF_W'(remaining);
            end
        end
    end

    // Lane offset never exceeds TILE_W, so a lane wraps into the next row at most once.
    for (genvar i = 0; i < NUM_CORES; i++) begin : g_lane
        logic [PX_W-1:0] col_raw, col;
        logic            wrap;
        assign col_raw   = px + PX_W'(lane_off[i]);
        assign wrap      = col_raw >= PX_W'(TILE_W);
        assign col       = wrap ? col_raw - PX_W'(TILE_W) : col_raw;
        assign lane_x[i] = x0_q + COORD_W'(col);
        assign lane_y[i] = y0_q + COORD_W'(py) + COORD_W'(wrap);
    end

    always_comb begin
        px_sum = px + PX_W'(n_issue);
        px_nxt = px_sum;
        py_nxt = py;
        if (px_sum >= PX_W'(TILE_W)) begin
            px_nxt = px_sum - PX_W'(TILE_W);
            py_nxt = py + PY_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (strobe) state_nxt = ST_RUN;
            ST_RUN: begin
                if (abort)                  state_nxt = ST_IDLE;
                else if (remaining == '0)   state_nxt = ST_DONE;
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_q       <= INTERLEAVED;
            x0_q         <= '0;
            y0_q         <= '0;
            px           <= '0;
            py           <= '0;
            issued_count <= '0;
            thread_valid <= '0;
            thread_x     <= '0;
            thread_y     <= '0;
        end else begin
            thread_valid <= lane_go;
            for (int i = 0; i < NUM_CORES; i++) begin
                if (lane_go[i]) begin
                    thread_x[i] <= lane_x[i];
                    thread_y[i] <= lane_y[i];
                end
            end
            if (state == ST_IDLE && strobe) begin
                mode_q       <= dispatch_mode_e'(mode);
                x0_q         <= x0;
                y0_q         <= y0;
                px           <= '0;
                py           <= '0;
                issued_count <= '0;
            end else if (|lane_go) begin
                px           <= px_nxt;
                py           <= py_nxt;
                issued_count <= issued_count + CNT_W'(n_issue);
            end
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_tile_thread_dispatcher.sv
// Directed + randomized bench for tile_thread_dispatcher: a pixel-index model
// predicts each lane's coordinate, valid bit, count and done/busy per cycle.
module tb_tile_thread_dispatcher;

    localparam int N     = 4;
    localparam int TW    = 8;
    localparam int TH    = 2;
    localparam int CW    = 12;
    localparam int TOT   = TW * TH;
    localparam int CNT_W = $clog2(TOT + 1);

    logic                 clk = 1'b0;
    logic                 reset_n, strobe, abort, mode;
    logic [CW-1:0]        x0, y0;
    logic [N-1:0]         core_full, thread_valid;
    logic [N-1:0][CW-1:0] thread_x, thread_y;
    logic                 busy, done;
    logic [CNT_W-1:0]     issued_count;

    int            n_assert = 0;
    int            n_fail   = 0;
    logic [CW-1:0] last_x [N];
    logic [CW-1:0] last_y [N];

    tile_thread_dispatcher #(.NUM_CORES(N), .TILE_W(TW), .TILE_H(TH), .COORD_W(CW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .strobe       (strobe),
        .abort        (abort),
        .mode         (mode),
        .x0           (x0),
        .y0           (y0),
        .core_full    (core_full),
        .thread_valid (thread_valid),
        .thread_x     (thread_x),
        .thread_y     (thread_y),
        .busy         (busy),
        .done         (done),
        .issued_count (issued_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic [N-1:0] ex_tv,
                                 input logic ex_busy, input logic ex_done, input int ex_cnt);
        chk({tag, ".valid"}, 64'(thread_valid), 64'(ex_tv));
        chk({tag, ".busy"},  64'(busy),         64'(ex_busy));
        chk({tag, ".done"},  64'(done),         64'(ex_done));
        chk({tag, ".count"}, 64'(issued_count), 64'(ex_cnt));
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s.x%0d", tag, i), 64'(thread_x[i]), 64'(last_x[i]));
            chk($sformatf("%s.y%0d", tag, i), 64'(thread_y[i]), 64'(last_y[i]));
        end
    endtask

    function automatic logic [CW-1:0] pix_x(input logic [CW-1:0] org, input int p);
        return CW'(int'(org) + p % TW);
    endfunction

    function automatic logic [CW-1:0] pix_y(input logic [CW-1:0] org, input int p);
        return CW'(int'(org) + p / TW);
    endfunction

    // pat: 0 never full, 1 core 2 full for first 3 cycles, 2 steady 4'b0010, 3 random
    task automatic run_tile(input logic [CW-1:0] x0v, input logic [CW-1:0] y0v, input logic modev,
                            input int pat, input int abort_idx, input bit strobe_mid);
        int           idx = 0;
        int           cnt;
        bit           finished = 0;
        logic [N-1:0] cf, ex_tv;
        x0 = x0v; y0 = y0v; mode = modev; strobe = 1'b1;
        tick();
        strobe = 1'b0;
        x0 = CW'($urandom); y0 = CW'($urandom); mode = ~modev;
        check_outputs("start", '0, 1'b1, 1'b0, 0);
        for (int c = 0; c < 200 && !finished; c++) begin
            if (idx == TOT) begin
                core_full = N'($urandom);
                tick();
                check_outputs("done", '0, 1'b0, 1'b1, TOT);
                tick();
                check_outputs("idle", '0, 1'b0, 1'b0, TOT);
                finished = 1;
            end else if (abort_idx >= 0 && idx >= abort_idx) begin
                abort = 1'b1; core_full = '0;
                tick();
                abort = 1'b0;
                check_outputs("abort", '0, 1'b0, 1'b0, idx);
                tick();
                check_outputs("post_abort", '0, 1'b0, 1'b0, idx);
                finished = 1;
            end else begin
                case (pat)
                    0:       cf = '0;
                    1:       cf = (c < 3) ? N'(4'b0100) : '0;
                    2:       cf = N'(4'b0010);
                    default: cf = modev ? N'($urandom)
                                        : (($urandom_range(0, 2) == 0) ? N'($urandom) : '0);
                endcase
                core_full = cf;
                strobe    = strobe_mid && (c == 1);
                ex_tv     = '0;
                cnt       = 0;
                for (int i = 0; i < N; i++) begin
                    if (!cf[i] && idx + cnt < TOT && (modev || cf == '0)) begin
                        ex_tv[i]  = 1'b1;
                        last_x[i] = pix_x(x0v, idx + cnt);
                        last_y[i] = pix_y(y0v, idx + cnt);
                        cnt++;
                    end
                end
                idx += cnt;
                tick();
                strobe = 1'b0;
                check_outputs("issue", ex_tv, 1'b1, 1'b0, idx);
            end
        end
        chk("tile_timeout", 64'(finished), 64'd1);
        core_full = '0;
    endtask

    initial begin
        reset_n = 1'b0; strobe = 1'b0; abort = 1'b0; mode = 1'b0;
        x0 = '0; y0 = '0; core_full = '0;
        for (int i = 0; i < N; i++) begin last_x[i] = '0; last_y[i] = '0; end
        tick(); tick();
        check_outputs("reset", '0, 1'b0, 1'b0, 0);
        reset_n = 1'b1;
        tick();
        check_outputs("post_reset", '0, 1'b0, 1'b0, 0);

        // Reset asserted mid-RUN clears everything asynchronously
        x0 = 12'd100; y0 = 12'd7; mode = 1'b0; strobe = 1'b1;
        tick();
        strobe = 1'b0;
        tick(); tick();
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin last_x[i] = '0; last_y[i] = '0; end
        check_outputs("mid_reset", '0, 1'b0, 1'b0, 0);
        tick();
        reset_n = 1'b1;
        tick();
        check_outputs("mid_reset_rel", '0, 1'b0, 1'b0, 0);

        run_tile(12'd10,   12'd20, 1'b0, 0, -1, 1'b0);   // lockstep, no stalls
        run_tile(12'd10,   12'd20, 1'b0, 1, -1, 1'b0);   // lockstep, core 2 stalls 3 cycles
        run_tile(12'd10,   12'd20, 1'b1, 2, -1, 1'b0);   // dynamic, core 1 always full
        run_tile(12'd10,   12'd20, 1'b0, 0,  8, 1'b0);   // abort after 2 groups
        run_tile(12'd10,   12'd20, 1'b0, 0, -1, 1'b0);   // restart from origin
        run_tile(12'd4094, 12'd5,  1'b0, 0, -1, 1'b1);   // x wrap, strobe ignored in RUN
        run_tile(12'd4093, 12'd4095, 1'b1, 0, -1, 1'b0); // dynamic, x and y wrap
        for (int t = 0; t < 6; t++)
            run_tile(CW'($urandom), CW'($urandom), 1'($urandom), 3,
                     ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, TOT - 1)) : -1,
                     1'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/tile_thread_dispatcher.md
# tile_thread_dispatcher

Parametrised successor to the fixed-width thread generator: walks a rectangular pixel tile and issues one fragment-thread coordinate per ray-core lane, under per-core FIFO-full backpressure. Adds configurable core count and tile size, start/abort control, a done pulse, and a dynamic dispatch mode that fills whichever cores have room. Sits between render-state/control and the ray-core array.

## Interface
- NUM_CORES, 4, ray-core lanes; ≥1, and TILE_W % NUM_CORES == 0
- TILE_W, 16, tile width in pixels
- TILE_H, 16, tile height in pixels
- COORD_W, 12, coordinate width
- clk  in  1  clock; all state on rising edge
- reset_n  in  1  asynchronous, active-low reset
- strobe  in  1  start a tile; sampled in IDLE only
- abort  in  1  cancel current tile
- mode  in  1  0 = lockstep interleaved, 1 = dynamic; latched on start
- x0, y0  in  COORD_W  tile origin; latched on start
- core_full  in  NUM_CORES  per-core input FIFO full
- thread_valid  out  NUM_CORES  registered; lane carries a thread this cycle
- thread_x, thread_y  out  NUM_CORES×COORD_W  registered pixel coordinate per lane
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse after the last thread issues
- issued_count  out  $clog2(TILE_W*TILE_H+1)  threads issued in current/last tile

## Operation
- States: IDLE, RUN, DONE.
- IDLE: strobe=1 → latch x0, y0, mode; clear px, py, issued_count; go RUN.
- RUN, per cycle, with free[i] = !core_full[i]:
  - mode 0: if all free, issue NUM_CORES consecutive pixels, lane i gets pixel base+i; else issue nothing.
  - mode 1: issue consecutive pixels to free lanes in ascending index order; lane count = min(free lanes, remaining pixels).
- Pixel order row-major: x = x0 + px, y = y0 + py; px wraps at TILE_W and increments py. Advance ≤ NUM_CORES ≤ TILE_W, so at most one row wrap per cycle.
- Coordinate sums truncate to COORD_W bits (modulo 2^COORD_W).
- Remaining pixels reach 0 → DONE (one cycle, done=1) → IDLE.
- abort=1 in RUN or DONE → IDLE next cycle. Clear all thread_valid, no done pulse, keep issued_count. Abort has priority over issue and over strobe.
- strobe in RUN or DONE: ignored.
- core_full is never checked against a lane once it is issued. The core must absorb a thread whose full rose the same cycle it was sampled free.

## Timing
- Reset values: state IDLE; thread_valid 0; thread_x/y 0; busy 0; done 0; issued_count 0.
- Start latency: strobe at edge N → busy at N+1; first thread_valid at N+2 at earliest, since the issue decision in the first RUN cycle is registered.
- Backpressure: core_full sampled in cycle t governs thread_valid in cycle t+1.
- Throughput: NUM_CORES threads/cycle when unstalled. A TILE_W×TILE_H tile with no stalls takes TILE_W*TILE_H/NUM_CORES issue cycles.
- done asserts the cycle after the cycle that registers the last thread_valid.
- issued_count updates with thread_valid.
- thread_x/y of lanes with thread_valid=0 hold their previous value.

## Structure
- Shared package: dispatch_mode_e (INTERLEAVED, DYNAMIC), dispatcher state enum, and a per-lane thread_coord_t struct {x, y} replacing the separate x/y buses if the package already exports a coordinate type.
- One natural sub-module: free_lane_compactor. Combinational prefix count over free[]: gives each free lane its pixel offset plus the total issued. Used in mode 1; mode 0 uses the identity mapping.
- Elaboration check: assert TILE_W % NUM_CORES == 0.

## Test plan
- Reset: hold reset_n=0 mid-RUN, release → all outputs at reset values; state IDLE; no done.
- Mode 0, NUM_CORES=4, 8×2 tile, origin (10,20), never full → cycle 1 lanes x=10..13,y=20; cycle 2 x=14..17,y=20; cycle 3 y=21; cycle 4 y=21; done one cycle later; issued_count=16.
- Mode 0, core_full[2]=1 for 3 cycles → no thread_valid for 3 cycles, then groups resume in order with no pixel skipped or duplicated.
- Mode 1, core_full=4'b0010 steady, 8×2 tile → each cycle lanes 0,2,3 get consecutive x; row wrap mid-cycle correct; last cycle issues 1 thread; total 16.
- Abort after 2 groups → IDLE next cycle; thread_valid=0; no done; issued_count=8. A new strobe restarts from (x0,y0).
- Origin x0=4094, COORD_W=12 → x values wrap 4094,4095,0,1; strobe pulsed during RUN has no effect.
